// File: rtl/lectura_fecha.sv
// RTC date reader: three-byte burst over the multiplexed bus,
// BCD validation and coherent presentation of day/month/year.
module lectura_fecha #(
  parameter int         PHASE_CYC   = 4,
  parameter int         REFRESH_CYC = 1000000,
  parameter logic [7:0] ADDR_DIA    = 8'h24,
  parameter logic [7:0] ADDR_MES    = 8'h25,
  parameter logic [7:0] ADDR_YEAR   = 8'h26
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       EN,
  input  logic       req,
  input  logic [7:0] rtc_ad_i,
  output logic [7:0] rtc_ad_o,
  output logic       rtc_ad_oe,
  output logic       rtc_cs_n,
  output logic       rtc_rd_n,
  output logic       rtc_wr_n,
  output logic       rtc_a_d,
  output logic [7:0] dia,
  output logic [7:0] mes,
  output logic [7:0] year,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int CW = (PHASE_CYC > 1) ? $clog2(PHASE_CYC) : 1;
  localparam int RW = $clog2(REFRESH_CYC);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_GAP1, S_DATA, S_GAP2, S_DONE
  } state_t;

  state_t        r_state, w_nstate;
  logic [CW-1:0] r_cnt, w_ncnt;
  logic [RW-1:0] r_rcnt;
  logic [1:0]    r_idx, w_nidx;
  logic [7:0]    r_sh0, r_sh1, r_sh2;
  logic          w_trig, w_last, w_ok;
  logic          w_cs_n, w_rd_n, w_wr_n, w_a_d, w_oe;
  logic [7:0]    w_ad;

  function automatic logic f_bcd(input logic [7:0] b);
    return (b[7:4] <= 4'd9) && (b[3:0] <= 4'd9);
  endfunction

  assign w_last = (r_cnt == CW'(PHASE_CYC - 1));
  assign w_ok = f_bcd(r_sh0) && (r_sh0 != 8'h00)
             && (r_sh0 <= 8'h31)
             && f_bcd(r_sh1) && (r_sh1 != 8'h00)
             && (r_sh1 <= 8'h12)
             && f_bcd(r_sh2);

  always_comb begin
    w_nstate = r_state;
    w_nidx   = r_idx;
    w_ncnt   = '0;
    w_trig   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (EN && (req ||
            r_rcnt == RW'(REFRESH_CYC - 1))) begin
          w_trig   = 1'b1;
          w_nstate = S_ADDR;
          w_nidx   = 2'd0;
        end
      end
      S_ADDR: begin
        if (w_last) w_nstate = S_GAP1;
        else        w_ncnt   = r_cnt + 1'b1;
      end
      S_GAP1: w_nstate = S_DATA;
      S_DATA: begin
        if (w_last) w_nstate = S_GAP2;
        else        w_ncnt   = r_cnt + 1'b1;
      end
      S_GAP2: begin
        if (r_idx < 2'd2) begin
          w_nidx   = r_idx + 2'd1;
          w_nstate = S_ADDR;
        end else begin
          w_nstate = S_DONE;
        end
      end
      S_DONE:  w_nstate = S_IDLE;
      default: w_nstate = S_IDLE;
    endcase
    if (!EN) begin
      w_nstate = S_IDLE;
      w_ncnt   = '0;
    end
  end

  // Bus levels are decoded from the next state so they can be registered.
  always_comb begin
    w_cs_n = 1'b1;
    w_rd_n = 1'b1;
    w_wr_n = 1'b1;
    w_a_d  = 1'b1;
    w_oe   = 1'b0;
    w_ad   = 8'h00;
    unique case (w_nstate)
      S_ADDR: begin
        w_cs_n = 1'b0;
        w_a_d  = 1'b0;
        w_wr_n = 1'b0;
        w_oe   = 1'b1;
        unique case (w_nidx)
          2'd0:    w_ad = ADDR_DIA;
          2'd1:    w_ad = ADDR_MES;
          default: w_ad = ADDR_YEAR;
        endcase
      end
      S_DATA: begin
        w_cs_n = 1'b0;
        w_rd_n = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_rcnt    <= '0;
      r_idx     <= 2'd0;
      r_sh0     <= 8'h00;
      r_sh1     <= 8'h00;
      r_sh2     <= 8'h00;
      rtc_ad_o  <= 8'h00;
      rtc_ad_oe <= 1'b0;
      rtc_cs_n  <= 1'b1;
      rtc_rd_n  <= 1'b1;
      rtc_wr_n  <= 1'b1;
      rtc_a_d   <= 1'b1;
      dia       <= 8'h01;
      mes       <= 8'h01;
      year      <= 8'h00;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      r_state   <= w_nstate;
      r_cnt     <= w_ncnt;
      r_idx     <= w_nidx;
      rtc_ad_o  <= w_ad;
      rtc_ad_oe <= w_oe;
      rtc_cs_n  <= w_cs_n;
      rtc_rd_n  <= w_rd_n;
      rtc_wr_n  <= w_wr_n;
      rtc_a_d   <= w_a_d;
      busy      <= (w_nstate != S_IDLE);
      done      <= (w_nstate == S_DONE);
      if (!EN || w_trig)
        r_rcnt <= '0;
      else if (r_rcnt != RW'(REFRESH_CYC - 1))
        r_rcnt <= r_rcnt + 1'b1;
      if (r_state == S_DATA && w_last) begin
        unique case (r_idx)
          2'd0:    r_sh0 <= rtc_ad_i;
          2'd1:    r_sh1 <= rtc_ad_i;
          default: r_sh2 <= rtc_ad_i;
        endcase
      end
      if (r_state == S_DONE && EN) begin
        if (w_ok) begin
          dia  <= r_sh0;
          mes  <= r_sh1;
          year <= r_sh2;
          err  <= 1'b0;
        end else begin
          err  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/lectura_fecha.md
# lectura_fecha

Read-side companion to the date-edit path. Periodically, or on request, it runs a three-byte burst read of day, month and year from the RTC over the multiplexed address/data bus. It validates the BCD and presents a coherent date (`dia`, `mes`, `year`) to the display and edit logic. It owns the RTC bus only while `EN` is high; the write path owns it otherwise.

## Interface
Parameters:
- `PHASE_CYC`, 4: clock cycles per bus phase (address or data); legal range ≥2.
- `REFRESH_CYC`, 1000000: cycles between automatic bursts; ≥64.
- `ADDR_DIA`, 8'h24: RTC register address of the day byte.
- `ADDR_MES`, 8'h25: RTC register address of the month byte.
- `ADDR_YEAR`, 8'h26: RTC register address of the year byte.

Ports:
- `clk` in 1: clock.
- `reset` in 1: reset, synchronous, active-high.
- `EN` in 1: bus ownership and enable. Low means idle and abort.
- `req` in 1: one-cycle read request; ignored while busy.
- `rtc_ad_i` in 8: bus data from the RTC.
- `rtc_ad_o` out 8: address driven onto the bus.
- `rtc_ad_oe` out 1: high while `rtc_ad_o` drives the bus.
- `rtc_cs_n`, `rtc_rd_n`, `rtc_wr_n`, `rtc_a_d` out 1 each: chip select, read strobe, write strobe (address latch), address/data select (0 = address).
- `dia`, `mes`, `year` out 8 each: last valid BCD date.
- `busy` out 1: burst in progress.
- `done` out 1: one-cycle pulse when a burst completes, with or without error.
- `err` out 1: sticky; set on a non-BCD byte, cleared on the next clean burst.

## Operation
- States: IDLE, ADDR, GAP1, DATA, GAP2, DONE. A 2-bit index `idx` (0 = day, 1 = month, 2 = year) selects the address and the shadow register.
- Trigger: in IDLE with `EN`=1, either `req`=1 or the refresh counter reaching `REFRESH_CYC-1`. The counter reloads to 0 on every trigger and on `EN`=0.
- ADDR (`PHASE_CYC` cycles):
  - `cs_n`=0, `a_d`=0, `wr_n`=0, `rd_n`=1.
  - `ad_oe`=1, `ad_o`=address[idx].
- GAP1 (1 cycle): `cs_n`=1, all strobes=1, `ad_oe`=0.
- DATA (`PHASE_CYC` cycles):
  - `cs_n`=0, `a_d`=1, `rd_n`=0, `ad_oe`=0.
  - `rtc_ad_i` is sampled into shadow[idx] on the last DATA cycle.
- GAP2 (1 cycle): bus idle. If `idx`<2, increment `idx` and go to ADDR; else go to DONE.
- DONE (1 cycle):
  - `done`=1.
  - If all three shadows pass the checks below, copy them to `dia`/`mes`/`year` simultaneously and clear `err`.
  - Otherwise leave the outputs unchanged and set `err`.
  - Then return to IDLE.
- Validity checks on each shadow byte:
  - Both nibbles ≤9.
  - Day in 01–31.
  - Month in 01–12.
  - Year: any BCD value.
- Bus idle levels: `cs_n`=`rd_n`=`wr_n`=`a_d`=1, `ad_oe`=0, `ad_o`=0.
- `EN` falling in any non-IDLE state aborts the burst:
  - Next cycle: IDLE, bus at idle levels.
  - No `done` pulse; outputs and `err` unchanged; partial shadows discarded.
- `req` while busy is dropped, not queued.
- `req` coincident with the refresh trigger starts one burst.

## Timing
- Reset values:
  - `dia`=8'h01, `mes`=8'h01, `year`=8'h00.
  - `busy`=0, `done`=0, `err`=0.
  - Bus outputs at idle levels; refresh counter=0; state IDLE.
- `busy` is high from the first ADDR cycle through the DONE cycle inclusive.
- Trigger sampled at edge T:
  - First ADDR cycle starts at T+1.
  - Each byte takes 2·`PHASE_CYC`+2 cycles.
  - `done` is high in cycle T+1+3·(2·`PHASE_CYC`+2), which is T+31 with defaults.
  - The new date is visible the cycle after `done`.
- Bus outputs are registered, with no combinational path from inputs.
- `cs_n` deasserts for at least one cycle between phases.
- `reset` mid-burst: next cycle has the reset values, with bus idle.

## Test plan
- Clean burst, `PHASE_CYC`=4:
  - Stimulus: bus model returns 8'h29, 8'h02, 8'h16 for addresses 24/25/26; pulse `req` at T.
  - Required: `ad_o` shows 24, 25, 26 in ADDR phases; `done` at T+31; then `dia`=29, `mes`=02, `year`=16, `err`=0.
- Invalid data:
  - Stimulus: month returns 8'h1A, then in a second burst 8'h13.
  - Required: both bursts give `done`, outputs unchanged, `err`=1; a following clean burst clears `err`.
- Abort: drop `EN` in the second DATA phase → idle bus next cycle, no `done`, outputs unchanged.
- Refresh:
  - Stimulus: `REFRESH_CYC`=100, `EN` held high, no `req`.
  - Required: bursts start every 100 cycles after previous trigger; `req` during busy produces no extra burst.
- Reset mid-burst: assert `reset` during an ADDR phase → all outputs at reset values next cycle, `cs_n`=1.
